// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the pipeline requesters, the memory arbiter and the
// unified memory/bus bridge. Signal names keep the arbiter's original port
// names so existing connection lists map one-to-one.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // pipeline control
  logic              i_flush;

  // fetch (IF) read port
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_ack;
  logic [DATA_W-1:0] o_if_rdata;

  // memory-access (MA) load/store port
  logic              i_ma_req;
  logic              i_ma_we;
  logic [ADDR_W-1:0] i_ma_addr;
  logic [DATA_W-1:0] i_ma_wdata;
  logic [BE_W-1:0]   i_ma_be;
  logic              o_ma_ack;
  logic [DATA_W-1:0] o_ma_rdata;

  // shared bus towards the memory/bus bridge
  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [DATA_W-1:0] o_bus_wdata;
  logic [BE_W-1:0]   o_bus_be;
  logic              i_bus_ack;
  logic [DATA_W-1:0] i_bus_rdata;

  // status
  logic              o_busy;

  // arbiter view
  modport slave (
    input  i_flush,
    input  i_if_req, i_if_addr,
    output o_if_ack, o_if_rdata,
    input  i_ma_req, i_ma_we, i_ma_addr, i_ma_wdata, i_ma_be,
    output o_ma_ack, o_ma_rdata,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    input  i_bus_ack, i_bus_rdata,
    output o_busy
  );

  // environment view (pipeline requesters + bus bridge)
  modport master (
    output i_flush,
    output i_if_req, i_if_addr,
    input  o_if_ack, o_if_rdata,
    output i_ma_req, i_ma_we, i_ma_addr, i_ma_wdata, i_ma_be,
    input  o_ma_ack, o_ma_rdata,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    output i_bus_ack, i_bus_rdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch (IF) and the
// memory-access stage (MA). One transaction at a time, MA has fixed priority,
// and a starvation counter forces an IF grant after STARVE_MAX consecutive MA
// grants taken while IF was waiting. A flush cancels only IF traffic: an IF
// transaction already on the bus completes but its ack is suppressed.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned BE_W         = DATA_W / 8;
  localparam logic [3:0]  C_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MA_BUSY = 2'd1,
    S_IF_BUSY = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_nxt;
  logic              r_drop;
  logic              w_drop_nxt;

  logic              r_bus_we;
  logic              w_bus_we_nxt;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [ADDR_W-1:0] w_bus_addr_nxt;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] w_bus_wdata_nxt;
  logic [BE_W-1:0]   r_bus_be;
  logic [BE_W-1:0]   w_bus_be_nxt;

  logic              w_if_elig;
  logic              w_if_starved;
  logic              w_ma_win;
  logic              w_if_win;
  logic              w_busy;
  logic              w_done;

  // Arbitration decode: MA wins unless IF is eligible and has been starved.
  // The counter can pass STARVE_MAX while a flush masks IF, so the guard uses
  // >= to stay effective once the flush ends.
  always_comb begin
    w_if_elig    = bus.i_if_req && !bus.i_flush;
    w_if_starved = w_if_elig && (r_starve_cnt >= C_STARVE_MAX);
    w_ma_win     = bus.i_ma_req && !w_if_starved;
    w_if_win     = !w_ma_win && w_if_elig;
    w_busy       = (r_state != S_IDLE);
    w_done       = w_busy && bus.i_bus_ack;
  end

  // Next-state, bus field latching, starvation counter and flush-drop flag.
  always_comb begin
    w_state_nxt     = r_state;
    w_starve_nxt    = r_starve_cnt;
    w_drop_nxt      = r_drop;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_bus_be_nxt    = r_bus_be;

    unique case (r_state)
      S_IDLE: begin
        w_drop_nxt = 1'b0;
        if (w_ma_win) begin
          w_state_nxt     = S_MA_BUSY;
          w_bus_we_nxt    = bus.i_ma_we;
          w_bus_addr_nxt  = bus.i_ma_addr;
          w_bus_wdata_nxt = bus.i_ma_wdata;
          w_bus_be_nxt    = bus.i_ma_we ? bus.i_ma_be : '1;
          if (!bus.i_if_req) begin
            w_starve_nxt = '0;
          end else if (r_starve_cnt != 4'hF) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
          end
        end else if (w_if_win) begin
          w_state_nxt     = S_IF_BUSY;
          w_bus_we_nxt    = 1'b0;
          w_bus_addr_nxt  = bus.i_if_addr;
          w_bus_wdata_nxt = '0;
          w_bus_be_nxt    = '1;
          w_starve_nxt    = '0;
        end
      end

      S_MA_BUSY: begin
        if (bus.i_bus_ack) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_IF_BUSY: begin
        if (bus.i_bus_ack) begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
        end else if (bus.i_flush) begin
          w_drop_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_be     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_drop       <= w_drop_nxt;
      r_bus_we     <= w_bus_we_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
      r_bus_be     <= w_bus_be_nxt;
    end
  end

  // Output drive: acks and read data are combinational with the bus ack;
  // an IF ack is suppressed when a flush is pending or arrives with the ack.
  always_comb begin
    bus.o_bus_req   = w_busy;
    bus.o_busy      = w_busy;
    bus.o_bus_we    = r_bus_we;
    bus.o_bus_addr  = r_bus_addr;
    bus.o_bus_wdata = r_bus_wdata;
    bus.o_bus_be    = r_bus_be;
    bus.o_ma_ack    = w_done && (r_state == S_MA_BUSY);
    bus.o_if_ack    = w_done && (r_state == S_IF_BUSY) && !r_drop && !bus.i_flush;
    bus.o_ma_rdata  = bus.i_bus_rdata;
    bus.o_if_rdata  = bus.i_bus_rdata;
  end

  // Requesters must hold req until their ack; a flushed IF request is exempt.
  a_ma_req_held : assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state == S_MA_BUSY) |-> bus.i_ma_req);

  a_if_req_held : assert property (@(posedge i_clk) disable iff (i_rst)
    ((r_state == S_IF_BUSY) && !r_drop && !bus.i_flush) |-> bus.i_if_req);

endmodule
